lu_share_arbiter: RTL
=====================

// Module: lu_share_arbiter
// PURPOSE
//  Shares one 4-bit logic unit (AND/OR/XOR/COMPLEMENT, 2-bit select) among NREQ requesters.
//  Round-robin arbitration; grantee's A/B/S latched into registers that drive the LU.
//  LU result captured and returned with a one-cycle done pulse to the owner.
//  Sits between the ALU-level controllers and the single shared logic-unit instance.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  W      4   operand/result width; must match LU width
// PORTS
//  clk      in   1        rising-edge clock, single clock domain
//  rst      in   1        synchronous, active-high reset
//  req      in   NREQ     request per requester; held high until done seen
//  a_in     in   NREQ*W   operand A per requester, slice i = [i*W +: W]
//  b_in     in   NREQ*W   operand B per requester
//  s_in     in   NREQ*2   op select per requester: 00 AND, 01 OR, 10 XOR, 11 ~A
//  lu_a     out  W        registered operand A to LU
//  lu_b     out  W        registered operand B to LU
//  lu_s     out  2        registered select to LU
//  lu_y     in   W        combinational LU result
//  y_out    out  W        captured result, valid while done != 0
//  done     out  NREQ     one-hot completion pulse, one cycle
//  busy     out  1        high in EXEC and DONE
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, lu_a/lu_b/lu_s=0, y_out=0, done=0, busy=0, ptr=0.
//  Reset mid-operation aborts the op; no done pulse is emitted for it.
//  FSM states IDLE, EXEC, DONE:
//   IDLE: if |req, pick winner = first set req at or after ptr (wrapping modulo NREQ);
//         latch a_in/b_in/s_in slices of winner into lu_a/lu_b/lu_s, owner<=winner, ->EXEC.
//         If req==0, stay IDLE, lu_* hold their values.
//   EXEC: one cycle; lu_y settles; at edge y_out<=lu_y, done<=onehot(owner), ->DONE.
//   DONE: done[owner]=1 and y_out valid for exactly this cycle; req ignored;
//         ptr<=(owner+1) mod NREQ; at edge done<=0, ->IDLE.
//  Latency: req seen in IDLE at edge t -> done high during cycle t+2..t+3; 3 cycles/op min.
//  Requester must drop req on the edge ending its done cycle; a req still high in IDLE
//   is a new request and re-arbitrated normally (after the others, by ptr rotation).
//  req deassertion during EXEC/DONE does not cancel: op completes, done still pulses.
//  Operand changes on a_in/b_in/s_in after the IDLE grant edge have no effect.
//  Simultaneous requests: strictly round-robin; no requester starves (max wait NREQ ops).
//  ptr wrap: owner=NREQ-1 -> ptr=0.
//  y_out holds last result after DONE until the next EXEC capture; done is the only qualifier.
//  Widths: no arithmetic on data; ptr/owner are clog2(NREQ) bits, wrap explicitly.
// STRUCTURE
//  Include file lu_ctrl_defs.vh: state encodings ST_IDLE/ST_EXEC/ST_DONE,
//   op codes OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11.
//  One sub-module: rr_pick (NREQ-bit req + ptr in -> winner index + any flag, combinational).
//  LU itself is instantiated at the parent level, not inside this block.
// TESTING
//  1 Reset: rst held 2 cycles with req=4'b1111 -> done=0, busy=0, y_out=0, lu_*=0.
//  2 Single op: req[2]=1, A=4'b1100, B=4'b1010, S=01 -> lu_s=01 next cycle,
//    done=4'b0100, y_out=4'b1110 two cycles after grant; busy high EXEC+DONE.
//  3 Contention: req=4'b1011 held, each drops after its done -> done order 0,1,3,
//    then ptr=0; re-raise req[1] with req[0] -> req[0] wins since ptr=0.
//  4 Wrap: ptr=3 (after owner 2), req=4'b1001 -> owner 3 first, then 0.
//  5 Withdrawal: req[1] dropped in EXEC, S=11, A=4'b0101 -> done[1] still pulses, y_out=4'b1010.
//  6 Reset in EXEC: rst at EXEC edge -> no done pulse, IDLE, ptr=0, outputs zero.

Source files
------------

// File: rtl/lu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module : lu_share_arbiter_pkg
//  Brief  : FSM state encodings and logic-unit op codes for the shared LU arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
package lu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/lu_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module : lu_share_arbiter_rr_pick
//  Brief  : Combinational round-robin pick: first set req at or after ptr.
//  Rev    : 1.0  initial release
// ============================================================================
module lu_share_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);

    int            w_sum;
    logic [PW-1:0] w_idx;

    // Walk from farthest to nearest so the candidate closest to ptr is written last.
    always_comb begin
        winner = '0;
        any    = |req;
        w_sum  = 0;
        w_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_idx = PW'(w_sum);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : lu_share_arbiter
//  Brief  : Round-robin sharing of one external 4-bit logic unit among NREQ users.
//  Rev    : 1.0  initial release
// ============================================================================
module lu_share_arbiter
    import lu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    input  logic [NREQ*2-1:0] s_in,
    output logic [W-1:0]      lu_a,
    output logic [W-1:0]      lu_b,
    output logic [1:0]        lu_s,
    input  logic [W-1:0]      lu_y,
    output logic [W-1:0]      y_out,
    output logic [NREQ-1:0]   done,
    output logic              busy
);

    localparam int PW = $clog2(NREQ);
    localparam logic [PW-1:0] c_last = PW'(NREQ - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   w_winner;
    logic            w_any;
    logic [W-1:0]    r_lu_a;
    logic [W-1:0]    r_lu_b;
    logic [1:0]      r_lu_s;
    logic [W-1:0]    r_y;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] w_owner_onehot;

    lu_share_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_owner_onehot = NREQ'(1) << r_owner;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands are frozen at the grant edge; later a_in/b_in/s_in changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_lu_a  <= '0;
            r_lu_b  <= '0;
            r_lu_s  <= '0;
            r_y     <= '0;
            r_done  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_lu_a  <= a_in[w_winner*W +: W];
                        r_lu_b  <= b_in[w_winner*W +: W];
                        r_lu_s  <= s_in[w_winner*2 +: 2];
                        r_owner <= w_winner;
                    end
                end
                ST_EXEC: begin
                    r_y    <= lu_y;
                    r_done <= w_owner_onehot;
                end
                ST_DONE: begin
                    r_done <= '0;
                    r_ptr  <= (r_owner == c_last) ? '0 : r_owner + 1'b1;
                end
                default: r_done <= '0;
            endcase
        end
    end

    assign lu_a  = r_lu_a;
    assign lu_b  = r_lu_b;
    assign lu_s  = r_lu_s;
    assign y_out = r_y;
    assign done  = r_done;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire
